// File: rtl/data_memory_sized.sv
// data_memory_sized
// Byte-addressed, little-endian data memory for the MEM stage of the 64-bit
// RISC-V pipeline. Supports byte/half/word/doubleword loads and stores with
// sign or zero extension on loads, a one-cycle registered response, error
// flagging for misaligned or out-of-range accesses, a post-reset clear
// sequencer, and a combinational doubleword debug read port.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   req_valid     request present this cycle
//   req_ready     block accepts a request this cycle (high only once cleared)
//   req_write     1 = store, 0 = load
//   req_size      0 = byte, 1 = half, 2 = word, 3 = doubleword
//   req_unsigned  zero-extend loads when 1, sign-extend when 0
//   req_addr      byte address
//   req_wdata     store data, low 8*2^req_size bits used
//   rsp_valid     response for the request accepted at the previous edge
//   rsp_rdata     extended load data, 0 for stores and errors
//   rsp_err       accepted request was misaligned or out of range
//   dbg_idx       debug doubleword index
//   dbg_data      doubleword at byte address dbg_idx*8 (combinational)

module data_memory_sized #(
   parameter int DEPTH_BYTES = 256,
   parameter int IDX_W       = $clog2(DEPTH_BYTES / 8)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [63:0]      req_addr,
   input  logic [63:0]      req_wdata,
   output logic             rsp_valid,
   output logic [63:0]      rsp_rdata,
   output logic             rsp_err,
   input  logic [IDX_W-1:0] dbg_idx,
   output logic [63:0]      dbg_data
);

   localparam int ADDR_W = $clog2(DEPTH_BYTES);

   typedef enum logic {
      CLEAR,
      IDLE
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  clr_cnt;
   logic [7:0]        mem [DEPTH_BYTES];

   logic [3:0]        nbytes;
   logic [2:0]        align_mask;
   logic [64:0]       addr_end;
   logic              misaligned;
   logic              out_of_range;
   logic              illegal;
   logic              accept;
   logic [ADDR_W-1:0] base;
   logic [63:0]       load_raw;
   logic [63:0]       load_ext;
   logic              sign_ext;

   // Decode access size and legality. The end address is formed in 65 bits
   // so that addresses near 2^64 cannot wrap around into the valid range.
   always_comb begin
      nbytes     = 4'd1;
      align_mask = 3'd0;
      case (req_size)
         2'd0: begin nbytes = 4'd1; align_mask = 3'd0; end
         2'd1: begin nbytes = 4'd2; align_mask = 3'd1; end
         2'd2: begin nbytes = 4'd4; align_mask = 3'd3; end
         default: begin nbytes = 4'd8; align_mask = 3'd7; end
      endcase
      addr_end     = {1'b0, req_addr} + 65'(nbytes);
      misaligned   = |(req_addr[2:0] & align_mask);
      out_of_range = addr_end > 65'(DEPTH_BYTES);
      illegal      = misaligned | out_of_range;
      accept       = req_valid & req_ready;
      base         = req_addr[ADDR_W-1:0];
   end

   // Gather the addressed bytes and extend them to 64 bits. Bytes beyond the
   // access size stay zero, so only the fill above the top byte differs.
   always_comb begin
      load_raw = '0;
      for (int k = 0; k < 8; k++) begin
         if (4'(k) < nbytes) begin
            load_raw[8*k +: 8] = mem[base + ADDR_W'(k)];
         end
      end
      sign_ext = ~req_unsigned;
      case (req_size)
         2'd0:    load_ext = {{56{sign_ext & load_raw[7]}},  load_raw[7:0]};
         2'd1:    load_ext = {{48{sign_ext & load_raw[15]}}, load_raw[15:0]};
         2'd2:    load_ext = {{32{sign_ext & load_raw[31]}}, load_raw[31:0]};
         default: load_ext = load_raw;
      endcase
   end

   // Control FSM and response registers. req_ready is a registered copy of
   // "state is IDLE" so it has no path from the request inputs. The response
   // is rebuilt every cycle, which also clears rdata/err on idle cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= CLEAR;
         clr_cnt   <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= accept;
         rsp_err   <= accept & illegal;
         rsp_rdata <= (accept && !illegal && !req_write) ? load_ext : '0;
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == {IDX_W{1'b1}}) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

   // Storage array. During CLEAR one doubleword is zeroed per edge; in IDLE
   // only legal accepted stores write. Illegal requests never touch memory.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR) begin
            for (int k = 0; k < 8; k++) begin
               mem[{clr_cnt, 3'(k)}] <= 8'h00;
            end
         end else if (accept && !illegal && req_write) begin
            for (int k = 0; k < 8; k++) begin
               if (4'(k) < nbytes) begin
                  mem[base + ADDR_W'(k)] <= req_wdata[8*k +: 8];
               end
            end
         end
      end
   end

   // Debug read of one little-endian doubleword.
   always_comb begin
      dbg_data = '0;
      for (int k = 0; k < 8; k++) begin
         dbg_data[8*k +: 8] = mem[{dbg_idx, 3'(k)}];
      end
   end

endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized
// Self-checking bench for data_memory_sized (DEPTH_BYTES = 256). A byte-array
// reference model computes expected load data and error flags directly from
// the access rules; fixed vectors, hand sequences and random traffic are
// compared against it.

module tb_data_memory_sized;

   localparam int DEPTH = 256;
   localparam int IDX_W = 5;

   logic             clk;
   logic             reset;
   logic             req_valid;
   logic             req_ready;
   logic             req_write;
   logic [1:0]       req_size;
   logic             req_unsigned;
   logic [63:0]      req_addr;
   logic [63:0]      req_wdata;
   logic             rsp_valid;
   logic [63:0]      rsp_rdata;
   logic             rsp_err;
   logic [IDX_W-1:0] dbg_idx;
   logic [63:0]      dbg_data;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] model_mem [DEPTH];

   typedef struct {
      string      name;
      bit         write;
      bit [1:0]   size;
      bit         uns;
      bit [63:0]  addr;
      bit [63:0]  wdata;
      bit [63:0]  exp_rdata;
      bit         exp_err;
   } vec_t;

   vec_t tbl[$];

   data_memory_sized #(.DEPTH_BYTES(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .dbg_idx      (dbg_idx),
      .dbg_data     (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic write, input logic [1:0] size,
                                input logic uns, input logic [63:0] addr, input logic [63:0] wdata);
      req_valid    = valid;
      req_write    = write;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void modelZero();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
   endfunction

   function automatic bit [63:0] modelDword(input int idx);
      bit [63:0] v = 0;
      for (int k = 0; k < 8; k++) v = v | (64'(model_mem[idx*8 + k]) << (8*k));
      return v;
   endfunction

   // Reference access: legality from plain arithmetic, load data assembled
   // byte by byte, then extended by OR-ing in the upper ones when negative.
   function automatic void modelAccess(input bit write, input bit [1:0] size, input bit uns,
                                       input bit [63:0] addr, input bit [63:0] wdata,
                                       output bit [63:0] rdata, output bit err);
      int        n    = 1 << size;
      bit [64:0] endv = {1'b0, addr} + 65'(n);
      err   = ((addr % 64'(n)) != 0) || (endv > 65'(DEPTH));
      rdata = 0;
      if (!err) begin
         if (write) begin
            for (int k = 0; k < n; k++) model_mem[int'(addr) + k] = wdata[8*k +: 8];
         end else begin
            for (int k = 0; k < n; k++) rdata = rdata | (64'(model_mem[int'(addr) + k]) << (8*k));
            if (!uns && n < 8 && rdata[8*n-1]) rdata = rdata | ~((64'd1 << (8*n)) - 64'd1);
         end
      end
   endfunction

   // Drive one request, clock it in and compare the response that follows.
   // req_valid is left high so callers can stream back-to-back requests.
   task automatic issueReq(input string name, input bit write, input bit [1:0] size, input bit uns,
                           input bit [63:0] addr, input bit [63:0] wdata,
                           input bit [63:0] exp_rdata, input bit exp_err);
      applyStimulus(1'b1, write, size, uns, addr, wdata);
      step();
      checkOutput({name, " rsp_valid"}, 64'(rsp_valid), 64'd1);
      checkOutput({name, " rsp_err"},   64'(rsp_err),   64'(exp_err));
      checkOutput({name, " rsp_rdata"}, rsp_rdata,      exp_rdata);
   endtask

   function automatic vec_t mk(input string name, input bit write, input bit [1:0] size, input bit uns,
                               input bit [63:0] addr, input bit [63:0] wdata,
                               input bit [63:0] exp_rdata, input bit exp_err);
      vec_t v;
      v.name = name; v.write = write; v.size = size; v.uns = uns;
      v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      return v;
   endfunction

   initial begin
      bit [63:0] er;
      bit        ee;
      int        edges;
      int        pulses;

      reset   = 1'b1;
      dbg_idx = '0;
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);

      // Reset values over three reset cycles
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("reset req_ready", 64'(req_ready), 64'd0);
         checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
         checkOutput("reset rsp_rdata", rsp_rdata,      64'd0);
         checkOutput("reset rsp_err",   64'(rsp_err),   64'd0);
      end

      // Clear sequence; a store is offered throughout and must not be taken
      reset = 1'b0;
      applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      for (int e = 1; e <= 32; e++) begin
         step();
         checkOutput($sformatf("clear req_ready edge %0d", e), 64'(req_ready), 64'(e == 32));
         checkOutput($sformatf("clear rsp_valid edge %0d", e), 64'(rsp_valid), 64'd0);
      end
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
      modelZero();
      for (int i = 0; i < 32; i++) begin
         dbg_idx = IDX_W'(i);
         #1;
         checkOutput($sformatf("cleared dbg %0d", i), dbg_data, 64'd0);
      end

      // Directed vectors with hand-derived expectations
      tbl.push_back(mk("dw store 0x18",    1, 3, 0, 64'h18, 64'h1122334455667788, 64'h0, 0));
      tbl.push_back(mk("dw load 0x18",     0, 3, 0, 64'h18, 64'h0, 64'h1122334455667788, 0));
      tbl.push_back(mk("b store 0x05",     1, 0, 0, 64'h05, 64'h80, 64'h0, 0));
      tbl.push_back(mk("lb 0x05",          0, 0, 0, 64'h05, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0));
      tbl.push_back(mk("lbu 0x05",         0, 0, 1, 64'h05, 64'h0, 64'h80, 0));
      tbl.push_back(mk("lh 0x04",          0, 1, 0, 64'h04, 64'h0, 64'hFFFF_FFFF_FFFF_8000, 0));
      tbl.push_back(mk("sw misaligned",    1, 2, 0, 64'h06, 64'hDEADBEEF, 64'h0, 1));
      tbl.push_back(mk("ld 0xFC",          0, 3, 0, 64'hFC, 64'h0, 64'h0, 1));
      tbl.push_back(mk("lb 0xFF",          0, 0, 0, 64'hFF, 64'h0, 64'h0, 0));
      tbl.push_back(mk("sw 0xFC top",      1, 2, 0, 64'hFC, 64'hCAFEF00D, 64'h0, 0));
      tbl.push_back(mk("lwu 0xFC",         0, 2, 1, 64'hFC, 64'h0, 64'hCAFEF00D, 0));
      tbl.push_back(mk("lw 0xFC",          0, 2, 0, 64'hFC, 64'h0, 64'hFFFF_FFFF_CAFE_F00D, 0));
      tbl.push_back(mk("lb 0x100 oor",     0, 0, 0, 64'h100, 64'h0, 64'h0, 1));
      tbl.push_back(mk("lh wrap addr",     0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h0, 1));
      tbl.push_back(mk("sh 0x20",          1, 1, 0, 64'h20, 64'h12347FFF, 64'h0, 0));
      tbl.push_back(mk("lh 0x20",          0, 1, 0, 64'h20, 64'h0, 64'h7FFF, 0));
      tbl.push_back(mk("lw 0x18",          0, 2, 0, 64'h18, 64'h0, 64'h55667788, 0));
      tbl.push_back(mk("lh 0x1E",          0, 1, 0, 64'h1E, 64'h0, 64'h1122, 0));
      tbl.push_back(mk("lh 0x05 misalign", 0, 1, 1, 64'h05, 64'h0, 64'h0, 1));
      foreach (tbl[i]) begin
         modelAccess(tbl[i].write, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, er, ee);
         issueReq(tbl[i].name, tbl[i].write, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                  tbl[i].exp_rdata, tbl[i].exp_err);
         applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
         step();
         checkOutput({tbl[i].name, " idle rsp_valid"}, 64'(rsp_valid), 64'd0);
      end
      dbg_idx = 5'd3;
      #1;
      checkOutput("dbg idx 3", dbg_data, 64'h1122334455667788);
      dbg_idx = 5'd0;
      #1;
      checkOutput("dbg idx 0 after bad store", dbg_data, 64'h0000_8000_0000_0000);

      // Reset while a load response is being presented
      modelAccess(1'b1, 2'd0, 1'b0, 64'h10, 64'hAB, er, ee);
      issueReq("sb 0x10", 1'b1, 2'd0, 1'b0, 64'h10, 64'hAB, er, ee);
      applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 64'h10, 64'd0);
      step();
      checkOutput("pre-reset load rsp_rdata", rsp_rdata, 64'hAB);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
      step();
      checkOutput("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("mid reset req_ready", 64'(req_ready), 64'd0);
      checkOutput("mid reset rsp_rdata", rsp_rdata,      64'd0);
      reset = 1'b0;
      edges = 0;
      while (!req_ready && edges < 100) begin
         step();
         edges++;
      end
      checkOutput("re-clear latency", 64'(edges), 64'd32);
      modelZero();
      dbg_idx = 5'd2;
      #1;
      checkOutput("dbg idx 2 after re-clear", dbg_data, 64'd0);

      // Back-to-back stream: store then load of the same word, valid held high
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         bit [63:0] a = 64'h40 + 64'(4 * (i / 2));
         bit [63:0] d = {$urandom, $urandom};
         bit        w = (i % 2) == 0;
         modelAccess(w, 2'd2, 1'b1, a, d, er, ee);
         issueReq($sformatf("stream %0d", i), w, 2'd2, 1'b1, a, d, er, ee);
         if (rsp_valid) pulses++;
      end
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
      step();
      if (rsp_valid) pulses++;
      checkOutput("stream pulse count", 64'(pulses), 64'd16);

      // Random traffic against the model, with idle gaps and debug reads
      for (int i = 0; i < 400; i++) begin
         bit        v  = $urandom_range(0, 3) != 0;
         bit [1:0]  sz = 2'($urandom_range(0, 3));
         int        r  = $urandom_range(0, 9);
         bit [63:0] a;
         bit [63:0] d  = {$urandom, $urandom};
         bit        w  = $urandom_range(0, 1) == 1;
         bit        u  = $urandom_range(0, 1) == 1;
         if (r == 0) a = {$urandom, $urandom};
         else a = 64'($urandom_range(0, DEPTH + 7));
         if (r < 7) a = a & ~((64'd1 << sz) - 64'd1);
         dbg_idx = IDX_W'($urandom_range(0, 31));
         if (v) begin
            modelAccess(w, sz, u, a, d, er, ee);
            issueReq($sformatf("rand %0d", i), w, sz, u, a, d, er, ee);
         end else begin
            applyStimulus(1'b0, w, sz, u, a, d);
            step();
            checkOutput($sformatf("rand %0d idle rsp_valid", i), 64'(rsp_valid), 64'd0);
            checkOutput($sformatf("rand %0d idle rsp_rdata", i), rsp_rdata,      64'd0);
            checkOutput($sformatf("rand %0d idle rsp_err", i),   64'(rsp_err),   64'd0);
         end
         checkOutput($sformatf("rand %0d dbg", i), dbg_data, modelDword(int'(dbg_idx)));
      end
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
      step();

      // Final sweep of the whole array through the debug port
      for (int i = 0; i < 32; i++) begin
         dbg_idx = IDX_W'(i);
         #1;
         checkOutput($sformatf("final dbg %0d", i), dbg_data, modelDword(i));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
